serial_word_tx: RTL and testbench

- Transmit side of the board's two-wire serial link (data + ready strobe).
- Accepts a 20-bit word (four 5-bit groups) and shifts it out MSB first, one bit per ready pulse.
- Holds every ready level long enough to pass the far-end debouncer, which requires 4 consistent samples at CLK/SAMPLE_DIV.
- Drives the receiver board, or a loopback into the local receiver for self-test.

---
 rtl/serial_word_tx.sv | 142 ++++++++++++++
 tb/tb_serial_word_tx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_tx.sv
// Transmit side of the two-wire serial link: shifts a WORD_BITS word out MSB first,
// one bit per ready pulse, with every ready level held long enough for the far-end debouncer.
module serial_word_tx #(
  parameter int unsigned SAMPLE_DIV  = 100,
  parameter int unsigned SETUP_TICKS = 2,
  parameter int unsigned HOLD_TICKS  = 8,
  parameter int unsigned WORD_BITS   = 20
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WORD_BITS-1:0] word_in,
  output logic                 data,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [4:0]           bit_count
);

  localparam int unsigned PW     = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned PH_MAX = (SETUP_TICKS > HOLD_TICKS) ? SETUP_TICKS : HOLD_TICKS;
  localparam int unsigned HW     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [HW-1:0]        phase_q, phase_d;
  // MSB is already on the data line, so only the remaining bits are stored
  logic [WORD_BITS-2:0] shreg_q, shreg_d;
  logic                 data_q, data_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [4:0]           cnt_q, cnt_d;
  logic                 tick;

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q <= IDLE;
      presc_q <= '0;
      phase_q <= '0;
      shreg_q <= '0;
      data_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      phase_q <= phase_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    phase_d = phase_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    tick    = (presc_q == PW'(SAMPLE_DIV - 1));

    if (busy_q) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d = word_in[WORD_BITS-2:0];
          data_d  = word_in[WORD_BITS-1];
          busy_d  = 1'b1;
          cnt_d   = '0;
          presc_d = '0;
          phase_d = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (tick) begin
          if (phase_q == HW'(SETUP_TICKS - 1)) begin
            phase_d = '0;
            ready_d = 1'b1;
            state_d = HIGH;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
      HIGH: begin
        if (tick) begin
          if (phase_q == HW'(HOLD_TICKS - 1)) begin
            phase_d = '0;
            ready_d = 1'b0;
            cnt_d   = cnt_q + 5'd1;
            state_d = LOW;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
      LOW: begin
        if (tick) begin
          if (phase_q == HW'(HOLD_TICKS - 1)) begin
            phase_d = '0;
            if (cnt_q < 5'(WORD_BITS)) begin
              data_d  = shreg_q[WORD_BITS-2];
              shreg_d = {shreg_q[WORD_BITS-3:0], 1'b0};
              state_d = SETUP;
            end else begin
              data_d  = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign data      = data_q;
  assign ready     = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign bit_count = cnt_q;

endmodule

// File: tb/tb_serial_word_tx.sv
// Scoreboard bench: a fast-timing instance checked edge-by-edge and by a word monitor,
// plus a default-timing instance looped into a debouncing receiver model.
module tb_serial_word_tx;

  logic        CLK = 1'b0;
  logic        reset;
  logic        start, start2;
  logic [19:0] word_in, word_in2;
  logic        data, ready, busy, done;
  logic [4:0]  bit_count;
  logic        data2, ready2, busy2, done2;
  logic [4:0]  bit_count2;

  int unsigned vectors = 0;
  int unsigned errors  = 0;
  int unsigned cyc     = 0;
  int unsigned t0      = 0;
  logic [19:0] exp_q[$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  serial_word_tx #(.SAMPLE_DIV(4), .SETUP_TICKS(1), .HOLD_TICKS(5), .WORD_BITS(20)) u_fast (
    .CLK(CLK), .reset(reset), .start(start), .word_in(word_in),
    .data(data), .ready(ready), .busy(busy), .done(done), .bit_count(bit_count)
  );

  serial_word_tx #(.SAMPLE_DIV(100), .SETUP_TICKS(2), .HOLD_TICKS(8), .WORD_BITS(20)) u_dflt (
    .CLK(CLK), .reset(reset), .start(start2), .word_in(word_in2),
    .data(data2), .ready(ready2), .busy(busy2), .done(done2), .bit_count(bit_count2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- monitor: pops the expected word at each done pulse
  logic [19:0] rx_sh;
  int unsigned rises;
  logic        p_ready = 1'b0, p_busy = 1'b0, p_data = 1'b0;
  logic [4:0]  p_bc = '0;

  always @(negedge CLK) begin
    if (busy && !p_busy) begin
      rx_sh = '0;
      rises = 0;
    end else begin
      if (busy && bit_count != p_bc) chk("bc_step", bit_count, p_bc + 5'd1);
      if (busy && p_busy && data != p_data) chk("ready_vs_data", ready, p_ready);
    end
    if (ready && !p_ready) begin
      rx_sh = {rx_sh[18:0], data};
      rises++;
    end
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        chk("rx_word", rx_sh, exp_q.pop_front());
        chk("ready_rises", rises, 20);
        chk("done_bc", bit_count, 20);
        chk("done_busy", busy, 0);
      end
    end
    p_ready = ready;
    p_busy  = busy;
    p_data  = data;
    p_bc    = bit_count;
  end

  // ---------------- debouncing receiver model on the default-timing instance
  int unsigned sdiv, agree, rx2_n;
  logic        clean;
  logic [19:0] rx2;

  always @(posedge CLK) begin
    if (!reset) begin
      sdiv <= 0; agree <= 0; clean <= 1'b0; rx2 <= '0; rx2_n <= 0;
    end else if (sdiv == 99) begin
      sdiv <= 0;
      if (ready2 != clean) begin
        if (agree == 3) begin
          clean <= ready2;
          agree <= 0;
          if (ready2) begin
            rx2   <= {rx2[18:0], data2};
            rx2_n <= rx2_n + 1;
          end
        end else begin
          agree <= agree + 1;
        end
      end else begin
        agree <= 0;
      end
    end else begin
      sdiv <= sdiv + 1;
    end
  end

  // ---------------- stimulus helpers (all called at a negedge)
  task automatic send(input logic [19:0] w, input bit expect_acc);
    start   = 1'b1;
    word_in = w;
    @(negedge CLK);
    start   = 1'b0;
    if (expect_acc) begin
      t0 = cyc;
      exp_q.push_back(w);
      chk("accept_busy", busy, 1);
      chk("accept_bc", bit_count, 0);
    end
  endtask

  task automatic wait_to(input int unsigned n);
    while (cyc < t0 + n) @(negedge CLK);
  endtask

  task automatic wait_done(input int unsigned budget, input string nm);
    int unsigned n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    chk(nm, done, 1);
  endtask

  initial begin
    int unsigned n;
    int unsigned par;
    reset = 1'b0; start = 1'b1; start2 = 1'b1;
    word_in = 20'hFFFFF; word_in2 = 20'hFFFFF;
    repeat (3) @(negedge CLK);
    chk("rst_data", data, 0);
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bc", bit_count, 0);
    chk("rst_busy2", busy2, 0);
    reset = 1'b1; start = 1'b0; start2 = 1'b0;
    repeat (3) @(negedge CLK);
    chk("idle_busy", busy, 0);
    chk("idle_ready", ready, 0);

    // timing of the first bits and of completion
    send(20'hA5C3F, 1);
    chk("t0_data", data, 1);
    wait_to(3);   chk("t3_ready", ready, 0);
    wait_to(4);   chk("t4_ready", ready, 1);
    wait_to(23);  chk("t23_ready", ready, 1);
    wait_to(24);  chk("t24_ready", ready, 0);
    chk("t24_bc", bit_count, 1);
    wait_to(43);  chk("t43_data", data, 1);
    wait_to(44);  chk("t44_data", data, 0);
    wait_to(100); send(20'h12345, 0);
    chk("ignored_busy", busy, 1);
    wait_to(879); chk("t879_done", done, 0);
    wait_to(880); chk("t880_done", done, 1);
    chk("t880_busy", busy, 0);

    // back-to-back: start on the cycle after done
    send(20'h00001, 1);
    chk("b2b_t0", t0, cyc);
    wait_to(1);   chk("b2b_done_cleared", done, 0);
    wait_done(1000, "b2b_done_timeout");
    @(negedge CLK);

    // reset while bit index 7 has ready high
    send(20'h3C96E, 1);
    n = 0;
    while (!(bit_count == 5'd7 && ready) && n < 1000) begin
      @(negedge CLK);
      n++;
    end
    chk("reach_bit7", {bit_count, ready}, {5'd7, 1'b1});
    reset = 1'b0;
    @(negedge CLK);
    reset = 1'b1;
    exp_q.delete();
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_data", data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_bc", bit_count, 0);
    @(negedge CLK);
    send(20'h5A5A5, 1);
    wait_done(1000, "post_rst_done_timeout");
    repeat (5) @(negedge CLK);
    chk("bc_holds", bit_count, 20);
    chk("pending_words", exp_q.size(), 0);

    // loopback of the default-timing instance through the debouncer model
    start2 = 1'b1; word_in2 = 20'hA5C3F;
    @(negedge CLK);
    start2 = 1'b0;
    chk("lb_busy", busy2, 1);
    n = 0;
    while (done2 !== 1'b1 && n < 40000) begin
      @(negedge CLK);
      n++;
    end
    chk("lb_done_timeout", done2, 1);
    chk("lb_bits", rx2_n, 20);
    chk("lb_word", rx2, 20'hA5C3F);
    par = 0;
    for (int g = 0; g < 4; g++) begin
      logic [4:0] grp;
      grp = rx2[g*5 +: 5];
      if (^grp == 1'b0) par++;
    end
    chk("lb_even_groups", par, 2);
    chk("lb_bc", bit_count2, 20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
